// File: rtl/ppwm_multi.sv
// Multi-channel PWM programmed over a synchronised 3-wire serial port.
// Shadow registers move to the active set only at a period boundary so outputs never glitch.
module ppwm_multi #(
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned ADDR_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_i,
  input  logic              clk_data_i,
  input  logic              latch_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              sync_o
);
  localparam int unsigned CW     = COUNTER_WIDTH;
  localparam int unsigned FRAME  = ADDR_W + COUNTER_WIDTH;
  localparam int unsigned CTRL_W = NUM_CH + 2;

  logic [2:0]        r_dat_sync;
  logic [2:0]        r_sck_sync;
  logic [2:0]        r_lat_sync;
  logic [FRAME-1:0]  r_sr;
  logic [FRAME-1:0]  r_frame;
  logic              r_commit;

  logic [CW-1:0]     r_sh_duty [NUM_CH];
  logic [CW-1:0]     r_sh_per;
  logic [CTRL_W-1:0] r_sh_ctrl;

  logic [CW-1:0]     r_duty [NUM_CH];
  logic [CW-1:0]     r_per;
  logic [NUM_CH-1:0] r_en;
  logic              r_center;
  logic              r_inv;

  logic [CW-1:0]     r_cnt;
  logic              r_dir;
  logic              r_bnd_d;
  logic [NUM_CH-1:0] r_pwm;
  logic              r_sync;

  logic              w_sck_edge;
  logic              w_lat_edge;
  logic [ADDR_W-1:0] w_addr;
  logic [CW-1:0]     w_val;
  logic              w_bnd;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_dir_nxt;
  logic [NUM_CH-1:0] w_pwm_nxt;

  assign w_sck_edge = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_lat_edge = r_lat_sync[1] & ~r_lat_sync[2];
  assign w_addr     = r_frame[FRAME-1:CW];
  assign w_val      = r_frame[CW-1:0];

  // Serial front end: synchronisers, shift register, frame capture on latch edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dat_sync <= '0;
      r_sck_sync <= '0;
      r_lat_sync <= '0;
      r_sr       <= '0;
      r_frame    <= '0;
      r_commit   <= 1'b0;
    end else begin
      r_dat_sync <= {r_dat_sync[1:0], data_i};
      r_sck_sync <= {r_sck_sync[1:0], clk_data_i};
      r_lat_sync <= {r_lat_sync[1:0], latch_i};
      if (w_sck_edge) r_sr <= {r_sr[FRAME-2:0], r_dat_sync[2]};
      if (w_lat_edge) r_frame <= r_sr;
      r_commit <= w_lat_edge;
    end
  end

  // Shadow writes and boundary transfer to the active set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sh_duty[i] <= '0;
        r_duty[i]    <= '0;
      end
      r_sh_per  <= '1;
      r_sh_ctrl <= '0;
      r_per     <= '1;
      r_en      <= '0;
      r_center  <= 1'b0;
      r_inv     <= 1'b0;
    end else begin
      if (r_commit) begin
        for (int i = 0; i < NUM_CH; i++)
          if (w_addr == ADDR_W'(i)) r_sh_duty[i] <= w_val;
        if (w_addr == ADDR_W'(NUM_CH))     r_sh_per  <= w_val;
        if (w_addr == ADDR_W'(NUM_CH + 1)) r_sh_ctrl <= w_val[CTRL_W-1:0];
      end
      if (w_bnd) begin
        for (int i = 0; i < NUM_CH; i++) r_duty[i] <= r_sh_duty[i];
        r_per    <= r_sh_per;
        r_en     <= r_sh_ctrl[NUM_CH-1:0];
        r_center <= r_sh_ctrl[NUM_CH];
        r_inv    <= r_sh_ctrl[NUM_CH+1];
      end
    end
  end

  // Counter sequencing; r_dir = 1 while counting down in center mode
  always_comb begin
    w_bnd     = 1'b0;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (r_per == '0)
      w_bnd = 1'b1;
    else if (!r_center)
      w_bnd = (r_cnt == r_per);
    else
      w_bnd = (r_dir && r_cnt == CW'(1)) || (r_cnt == r_per && r_per == CW'(1));

    if (w_bnd) begin
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b0;
    end else if (!r_center) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!r_dir && r_cnt == r_per) begin
      w_cnt_nxt = r_cnt - CW'(1);
      w_dir_nxt = 1'b1;
    end else if (r_dir) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Period zero forces enabled channels to the inactive level, which equals invert
  always_comb begin
    w_pwm_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_en[i])
        w_pwm_nxt[i] = (r_per == '0) ? r_inv : ((r_cnt < r_duty[i]) ^ r_inv);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_bnd_d <= 1'b0;
      r_pwm   <= '0;
      r_sync  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_bnd_d <= w_bnd;
      r_pwm   <= w_pwm_nxt;
      r_sync  <= r_bnd_d && (r_cnt == '0) && (r_per != '0);
    end
  end

  assign pwm_o  = r_pwm;
  assign sync_o = r_sync;
endmodule

// File: tb/tb_ppwm_multi.sv
// Directed self-checking bench for ppwm_multi (COUNTER_WIDTH=10, NUM_CH=4, ADDR_W=3).
module tb_ppwm_multi;
  logic       clk;
  logic       rst_n;
  logic       data_i;
  logic       clk_data_i;
  logic       latch_i;
  logic [3:0] pwm_o;
  logic       sync_o;

  int n_chk = 0;
  int n_err = 0;

  ppwm_multi dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .clk_data_i (clk_data_i),
    .latch_i    (latch_i),
    .pwm_o      (pwm_o),
    .sync_o     (sync_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    data_i = b;
    repeat (2) @(negedge clk);
    clk_data_i = 1'b1;
    repeat (3) @(negedge clk);
    clk_data_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic shift_word(input logic [12:0] w);
    for (int i = 12; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic pulse_latch();
    latch_i = 1'b1;
    repeat (4) @(negedge clk);
    latch_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [9:0] v);
    shift_word({a, v});
    pulse_latch();
  endtask

  // Leaves the bench at the negedge where sync_o is observed high
  task automatic wait_sync(input int limit, input string tag);
    int n = 0;
    @(negedge clk);
    while (!sync_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sync_o), 32'd1);
  endtask

  // Samples the current cycle first; earliest sample lands in the MSB
  task automatic capture(input int n, input int ch, output logic [31:0] pv, output logic [31:0] sv);
    pv = '0;
    sv = '0;
    for (int i = 0; i < n; i++) begin
      pv = {pv[30:0], pwm_o[ch]};
      sv = {sv[30:0], sync_o};
      @(negedge clk);
    end
  endtask

  // Raises latch d cycles after the sync cycle while recording ch0 over three periods
  task automatic timed_latch(input int d, output logic [31:0] pv);
    pv = '0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      pv = {pv[30:0], pwm_o[0]};
      if (i == d) latch_i = 1'b1;
      if (i == d + 4) latch_i = 1'b0;
    end
    latch_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] pv, sv;

  initial begin
    rst_n = 1'b0; data_i = 1'b0; clk_data_i = 1'b0; latch_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_i     = 1'($urandom_range(0, 1));
      clk_data_i = 1'($urandom_range(0, 1));
      latch_i    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("reset_pwm", 32'(pwm_o), 32'd0);
    check("reset_sync", 32'(sync_o), 32'd0);
    data_i = 1'b0; clk_data_i = 1'b0; latch_i = 1'b0;
    rst_n = 1'b1;
    capture(50, 0, pv, sv);
    check("post_reset_ch0", pv, 32'd0);
    check("post_reset_sync", sv, 32'd0);

    // Edge-aligned: period 4, duty0 2, ch0 enabled
    write_reg(3'd4, 10'd4);
    write_reg(3'd0, 10'd2);
    write_reg(3'd5, 10'h001);
    wait_sync(1500, "edge_first_sync");
    capture(10, 0, pv, sv);
    check("edge_pwm0", pv, 32'b1100011000);
    check("edge_sync", sv, 32'b1000010000);

    // Center-aligned, inverted, ch1 only
    write_reg(3'd1, 10'd2);
    write_reg(3'd5, 10'h032);
    repeat (12) @(negedge clk);
    wait_sync(20, "center_sync_found");
    capture(16, 1, pv, sv);
    check("center_pwm1", pv, 32'b0011111000111110);
    check("center_sync", sv, 32'b1000000010000000);
    wait_sync(20, "center_sync_found2");
    capture(8, 0, pv, sv);
    check("center_ch0_off", pv, 32'd0);

    // Shadow timing: mid-period write, then a write landing on the boundary
    write_reg(3'd5, 10'h001);
    repeat (12) @(negedge clk);
    shift_word({3'd0, 10'd1});
    wait_sync(20, "shadow_mid_sync");
    timed_latch(2, pv);
    check("shadow_mid", pv, 32'b110001100010000);
    shift_word({3'd0, 10'd2});
    wait_sync(20, "shadow_bnd_sync");
    timed_latch(0, pv);
    check("shadow_bnd", pv, 32'b100001000011000);

    // Limits
    write_reg(3'd0, 10'd0);
    repeat (12) @(negedge clk);
    capture(10, 0, pv, sv);
    check("duty0_zero", pv, 32'd0);
    write_reg(3'd0, 10'd5);
    repeat (12) @(negedge clk);
    capture(10, 0, pv, sv);
    check("duty_gt_per", pv, 32'h3FF);
    write_reg(3'd7, 10'd0);
    repeat (12) @(negedge clk);
    capture(10, 0, pv, sv);
    check("addr7_pwm", pv, 32'h3FF);
    check("addr7_sync", 32'($countones(sv)), 32'd2);
    write_reg(3'd4, 10'd0);
    repeat (12) @(negedge clk);
    capture(10, 0, pv, sv);
    check("per0_pwm", pv, 32'd0);
    check("per0_sync", sv, 32'd0);

    // 20-bit frame: only the last 13 bits count
    for (int i = 6; i >= 0; i--) shift_bit(7'b1011011 >> i);
    shift_word({3'd4, 10'd4});
    pulse_latch();
    repeat (4) @(negedge clk);
    capture(10, 0, pv, sv);
    check("long_frame_pwm", pv, 32'h3FF);
    check("long_frame_sync", 32'($countones(sv)), 32'd2);

    // Shift and latch edges together: pre-shift frame commits, shift still happens
    shift_word({3'd0, 10'd2});
    data_i = 1'b1;
    repeat (2) @(negedge clk);
    clk_data_i = 1'b1;
    latch_i    = 1'b1;
    repeat (4) @(negedge clk);
    clk_data_i = 1'b0;
    latch_i    = 1'b0;
    data_i     = 1'b0;
    repeat (12) @(negedge clk);
    wait_sync(20, "same_edge_sync");
    capture(5, 0, pv, sv);
    check("same_edge_commit", pv, 32'b11000);
    pulse_latch();
    repeat (12) @(negedge clk);
    capture(10, 0, pv, sv);
    check("same_edge_shifted", pv, 32'h3FF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ppwm_multi.md
Name: ppwm_multi

Overview:
Multi-channel successor to the single-channel serially programmed PWM. A synchronised 3-wire serial port (data, shift clock, latch) writes shadow registers for N duty cycles, a shared period and a control word. Shadow values transfer to the active set only at a period boundary, so output waveforms never glitch. Supports edge-aligned and center-aligned counting, per-channel enable and global polarity inversion.

Parameters:
COUNTER_WIDTH, 10, width of the counter, period and duty registers; must be >= NUM_CH+2.
NUM_CH, 4, number of PWM output channels (1..6).
ADDR_W, 3, serial address field width; must satisfy 2^ADDR_W >= NUM_CH+2.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
data_i  input  1  serial data, asynchronous to clk
clk_data_i  input  1  serial shift clock, asynchronous; data_i is sampled on its rising edge
latch_i  input  1  frame latch, asynchronous; its rising edge commits the frame
pwm_o  output  NUM_CH  registered PWM outputs
sync_o  output  1  one-cycle pulse at the start of each PWM period

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Synchronisation
  - data_i, clk_data_i and latch_i each pass through a 2-flop synchroniser, plus a third flop for edge detection on clk_data_i and latch_i.
  - data_i is delayed by the same depth, so it stays aligned with the detected edge.
- Shift register
  - FRAME = ADDR_W + COUNTER_WIDTH bits, shifted in MSB-first.
  - On each detected clk_data_i edge: sr <= {sr[FRAME-2:0], data}.
  - Extra bits are discarded from the top; only the last FRAME bits count.
- Commit
  - On a detected latch_i edge, sr is decoded the following cycle as addr = sr[FRAME-1:COUNTER_WIDTH], val = sr[COUNTER_WIDTH-1:0].
  - Address map: addr 0..NUM_CH-1 → shadow duty[addr]; addr NUM_CH → shadow period; addr NUM_CH+1 → shadow ctrl. Other addresses are ignored with no side effect.
  - ctrl layout: val[NUM_CH-1:0] = channel enables; val[NUM_CH] = center mode; val[NUM_CH+1] = invert.
  - Shift edge and latch edge detected in the same cycle: the commit uses the pre-shift sr, and the shift still occurs.
- Counter
  - Edge mode: 0,1,…,PER,0,… (PER+1 cycles per period).
  - Center mode: up 0→PER, then down PER-1→1, then 0 (2·PER cycles). Direction flips at PER and at 0.
  - Period boundary: the cycle whose next counter value is 0 (edge mode: cnt==PER; center mode: counting down with cnt==1, or cnt==PER when PER==1).
  - At a boundary, all shadows copy to active registers, so the next cycle (cnt=0) uses the new values.
  - A shadow write in the same cycle as a boundary is not transferred; it applies at the following boundary.
  - A mode change takes effect at the boundary; the counter restarts at 0 counting up.
- Output
  - pwm_o[i] at cycle t+1 = en[i] ? ((cnt_t < duty[i]) ^ invert) : 0. Disabled channels drive 0 regardless of invert.
  - duty=0 → constantly inactive level; duty>PER → constantly active level.
  - Center mode with 1≤duty≤PER → active for 2·duty-1 of every 2·PER cycles.
- Period zero
  - Active PER==0: counter is held at 0, all enabled outputs are driven to the inactive level, and every cycle counts as a boundary, so shadows transfer each cycle.
- sync_o
  - Registered, so it is aligned with pwm_o.
  - Pulses one cycle for each cnt==0 that follows a boundary. It does not pulse in the first period after reset, and it does not pulse when PER==0.
- Reset values (shadow and active)
  - duty = 0, period = 2^COUNTER_WIDTH-1, ctrl = 0 (all disabled, edge mode, no invert).
  - cnt = 0 counting up; sr = 0; synchroniser flops = 0.
  - pwm_o = 0, sync_o = 0.
  - Reset asserted mid-frame or mid-period discards the partial frame and any pending shadows.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random serial activity → pwm_o=0, sync_o=0; after release, ch0 stays 0 because it is disabled.
- Edge PWM: write period=4, duty0=2, ctrl=0b0001 → from the first boundary, pwm_o[0] repeats 1,1,0,0,0 (5-cycle period) and sync_o pulses every 5 cycles on the first high cycle.
- Center + invert: period=4, duty1=2, ctrl={invert=1, center=1, en=0b0010} → pwm_o[1] is low for 3 and high for 5 of every 8 cycles, centred on cnt=0.
- Shadow timing: mid-period, write duty0=1 → the current period is unchanged and the next period shows 1 high cycle; a write landing exactly on the boundary cycle applies one period later.
- Limits: duty0=0 gives constant 0, duty0=5 with period=4 gives constant 1, period=0 gives all enabled outputs inactive and no sync_o; ignored addr 7 changes nothing.
- Serial edge cases: shift 20 bits then latch → only the last 13 bits are used; shift edge and latch edge in the same cycle → the pre-shift value is committed.
